program_loader: RTL and testbench
=================================

# program_loader

Upstream loader for the writable program memory of the 6-bit core. It accepts a word-serial program image over a valid/ready stream and writes it into program memory starting at address 0. It holds the core in reset (via `cpu_nReset`) while loading and releases it only after the image checksum verifies. It sits between the external download link and the program memory / core reset input.

## Interface
- `ADDR_W`, 5, program memory address width (32 words)
- `INS_W`, 6, instruction width

- `clk`  in  1  system clock; all state changes on rising edge
- `nReset`  in  1  reset, asynchronous, active-low
- `load_req`  in  1  level request to start a download; sampled in RUN and ERR only
- `rx_valid`  in  1  stream word valid
- `rx_data`  in  INS_W  stream word
- `rx_ready`  out  1  stream ready; combinational from state only (1 in HDR, DATA, CHK)
- `pm_we`  out  1  program memory write enable, registered
- `pm_waddr`  out  ADDR_W  program memory write address, registered
- `pm_wdata`  out  INS_W  program memory write data, registered
- `cpu_nReset`  out  1  core reset, active-low, registered
- `busy`  out  1  1 in HDR, DATA, CHK
- `done`  out  1  one-cycle pulse on successful load
- `err`  out  1  1 while in ERR

## Operation
- A word is accepted on a cycle with `rx_valid && rx_ready`. One word per cycle is sustained.
- Image format: header, then LEN+1 instruction words, then checksum.
  - Header: bit5 must be 0; bits[4:0] = LEN = instruction count − 1 (0..31).
  - Checksum: XOR of all instruction words.
- States:
  - RUN: core runs. If `load_req`=1 → HDR.
  - HDR: on an accepted word:
    - if bit5=1 → ERR;
    - else latch LEN, clear addr and chk → DATA.
  - DATA: on each accepted word, issue a write to addr, then `chk ^= word`.
    - If addr==LEN → CHK;
    - else addr+1.
  - CHK: on an accepted word:
    - if word==chk → RUN and pulse `done`;
    - else → ERR.
  - ERR: hold the core in reset. If `load_req`=1 → HDR; `err` clears on leaving ERR.
- `load_req` is ignored in HDR, DATA and CHK. There is no abort mid-load; only `nReset` aborts.
- Partial or failed loads leave program memory partially overwritten. The core stays in reset until a good load completes.
- addr never exceeds LEN ≤ 31, so it never wraps.

## Timing
- Reset values:
  - state = RUN;
  - `cpu_nReset` = 0;
  - `pm_we` = 0, `pm_waddr` = 0, `pm_wdata` = 0;
  - `done` = 0, `err` = 0.
- First rising edge after `nReset` deasserts: `cpu_nReset` → 1, because the default memory contents run.
- `cpu_nReset` = 1 exactly when registered state == RUN. Consequences:
  - it drops to 0 one cycle after `load_req` is sampled in RUN;
  - it rises one cycle after the correct checksum is accepted, in the same cycle as `done`.
- Write latency: a word accepted in cycle n produces `pm_we`=1 with its address and data in cycle n+1, for exactly one cycle.
- Idle cycles (`rx_valid`=0) cause no state change.
- Asynchronous `nReset` mid-load returns to RUN immediately and drops any pending write.

## Structure
- Package `loader_pkg`:
  - `ADDR_W`, `INS_W` constants;
  - state enum {RUN, HDR, DATA, CHK, ERR};
  - header bit index for the reserved bit (5).
- Single module; no sub-modules. The writable program RAM is a separate block that consumes `pm_*`.
- The core reset used downstream is `nReset && cpu_nReset`.

## Test plan
- Reset release, no traffic → `cpu_nReset`=1 from the first edge; `busy`=0; no writes.
- `load_req`, then stream 0x02, 0x11, 0x22, 0x33, 0x00 (0x11^0x22^0x33=0x00) back-to-back:
  - writes (0,0x11), (1,0x22), (2,0x33) on consecutive cycles;
  - `done` pulses and `cpu_nReset`=1 one cycle after the checksum word.
- Same image with checksum 0x01 → `err`=1 and `cpu_nReset` stays 0. Then `load_req` → `err` clears and a good reload succeeds.
- Header 0x20 → ERR immediately; no writes.
- LEN=31 with 32 words, `rx_valid` toggled every other cycle:
  - addresses 0..31 written in order, no wrap;
  - correct checksum → `done`.
- `nReset` pulsed after 3 data words:
  - immediately: RUN, `pm_we`=0, `cpu_nReset`=0;
  - `cpu_nReset`=1 on the first edge after release.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the program loader.
//   ADDR_W       : program memory address width (32 words)
//   INS_W        : instruction / stream word width
//   HDR_RSVD_BIT : header bit that must be zero in a valid header
//   state_t      : loader states
package loader_pkg;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned INS_W        = 6;
  localparam int unsigned HDR_RSVD_BIT = 5;

  typedef enum logic [2:0] {
    RUN,
    HDR,
    DATA,
    CHK,
    ERR
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Word-serial program image loader for the 6-bit core.
// Accepts header / LEN+1 instruction words / XOR checksum over a valid/ready
// stream, writes the instructions to program memory from address 0, and holds
// the core in reset until an image with a matching checksum has been loaded.
// Ports:
//   clk, nReset            : clock, asynchronous active-low reset
//   load_req               : level request to start a download (RUN/ERR only)
//   rx_valid, rx_data      : stream input
//   rx_ready               : stream ready, decoded from state (HDR/DATA/CHK)
//   pm_we/pm_waddr/pm_wdata: registered program memory write port
//   cpu_nReset             : registered core reset, high only in RUN
//   busy                   : loader mid-image (HDR/DATA/CHK)
//   done                   : one-cycle pulse after a verified load
//   err                    : high while in ERR
module program_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [INS_W-1:0]  rx_data,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_waddr,
  output logic [INS_W-1:0]  pm_wdata,
  output logic              cpu_nReset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] addr;
  logic [INS_W-1:0]  chk;
  logic              accept;

  // Ready depends on the state register only, never on rx_valid.
  assign rx_ready = (state == HDR) || (state == DATA) || (state == CHK);
  assign busy     = rx_ready;
  assign accept   = rx_valid && rx_ready;

  // Loader FSM with registered write port, core reset and status.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= RUN;
      len        <= '0;
      addr       <= '0;
      chk        <= '0;
      pm_we      <= 1'b0;
      pm_waddr   <= '0;
      pm_wdata   <= '0;
      cpu_nReset <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      pm_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        RUN: begin
          // The reset value is 0, so the first edge out of reset releases
          // the core onto the default memory contents.
          if (load_req) begin
            state      <= HDR;
            cpu_nReset <= 1'b0;
          end else begin
            cpu_nReset <= 1'b1;
          end
        end
        HDR: begin
          if (accept) begin
            if (rx_data[HDR_RSVD_BIT]) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              len   <= rx_data[ADDR_W-1:0];
              addr  <= '0;
              chk   <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            pm_we    <= 1'b1;
            pm_waddr <= addr;
            pm_wdata <= rx_data;
            chk      <= chk ^ rx_data;
            // addr stops at LEN, so it never wraps.
            if (addr == len) begin
              state <= CHK;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        CHK: begin
          if (accept) begin
            if (rx_data == chk) begin
              state      <= RUN;
              done       <= 1'b1;
              cpu_nReset <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        ERR: begin
          if (load_req) begin
            state <= HDR;
            err   <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with an image-level
// reference model and directed literal checks of the key scenarios.
module tb_program_loader;
  import loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_req = 1'b0;
  logic              rx_valid = 1'b0;
  logic [INS_W-1:0]  rx_data = '0;
  logic              rx_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_waddr;
  logic [INS_W-1:0]  pm_wdata;
  logic              cpu_nReset;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  program_loader dut (
    .clk       (clk),
    .nReset    (rst_n),
    .load_req  (load_req),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .pm_we     (pm_we),
    .pm_waddr  (pm_waddr),
    .pm_wdata  (pm_wdata),
    .cpu_nReset(cpu_nReset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Image-level model: tracks position within the current image rather
  // than a state machine; word 0 is the header, then n data words, then
  // the checksum.
  bit              m_loading = 1'b0;
  bit              m_failed  = 1'b0;
  int              m_pos     = 0;
  int              m_n       = 0;
  logic [INS_W-1:0]  m_x     = '0;
  bit              e_cpu     = 1'b0;
  bit              e_we      = 1'b0;
  bit              e_done    = 1'b0;
  logic [ADDR_W-1:0] e_waddr = '0;
  logic [INS_W-1:0]  e_wdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b0;
      m_failed  = 1'b0;
      m_pos     = 0;
      m_n       = 0;
      m_x       = '0;
      e_cpu     = 1'b0;
      e_we      = 1'b0;
      e_done    = 1'b0;
      e_waddr   = '0;
      e_wdata   = '0;
    end else begin
      e_we   = 1'b0;
      e_done = 1'b0;
      if (!m_loading) begin
        if (load_req) begin
          m_loading = 1'b1;
          m_pos     = 0;
        end
      end else if (rx_valid) begin
        if (m_pos == 0) begin
          if (rx_data[5]) begin
            m_loading = 1'b0;
            m_failed  = 1'b1;
          end else begin
            m_n   = 32'(rx_data[4:0]) + 1;
            m_x   = '0;
            m_pos = 1;
          end
        end else if (m_pos <= m_n) begin
          e_we    = 1'b1;
          e_waddr = ADDR_W'(m_pos - 1);
          e_wdata = rx_data;
          m_x     = m_x ^ rx_data;
          m_pos++;
        end else begin
          m_loading = 1'b0;
          m_failed  = (rx_data != m_x);
          e_done    = !m_failed;
        end
      end
      e_cpu = !m_loading && !m_failed;
    end
  end

  // Per-cycle compare plus a log of observed writes for literal checks.
  logic [ADDR_W+INS_W-1:0] wlog[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    check("cpu_nReset", int'(cpu_nReset), int'(e_cpu));
    check("pm_we", int'(pm_we), int'(e_we));
    check("done", int'(done), int'(e_done));
    check("busy", int'(busy), int'(m_loading));
    check("rx_ready", int'(rx_ready), int'(m_loading));
    check("err", int'(err), int'(m_failed && !m_loading));
    if (e_we || !rst_n) begin
      check("pm_waddr", int'(pm_waddr), int'(e_waddr));
      check("pm_wdata", int'(pm_wdata), int'(e_wdata));
    end
    if (pm_we) wlog.push_back({pm_waddr, pm_wdata});
    if (done) done_cnt++;
  end

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Gap cycles carry load_req noise, which must be ignored mid-load.
  task automatic send_word(input logic [INS_W-1:0] w, input int gap);
    int waited;
    waited = 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = INS_W'($urandom);
      load_req = m_loading ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    load_req = 1'b0;
    rx_valid = 1'b1;
    rx_data  = w;
    while (!rx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [INS_W-1:0] x;
    logic [INS_W-1:0] w;
    logic [ADDR_W+INS_W-1:0] ent;
    int len;
    int mode;
    int kind;

    #1 rst_n = 1'b0;
    cyc(3);
    check("rst_cpu", int'(cpu_nReset), 0);
    check("rst_we", int'(pm_we), 0);
    check("rst_waddr", int'(pm_waddr), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_cpu", int'(cpu_nReset), 1);
    check("release_busy", int'(busy), 0);
    cyc(3);
    check("idle_writes", wlog.size(), 0);

    // Directed good image, back-to-back.
    wlog.delete();
    done_cnt = 0;
    pulse_load();
    check("load_cpu_low", int'(cpu_nReset), 0);
    send_word(6'h02, 0);
    send_word(6'h11, 0);
    send_word(6'h22, 0);
    send_word(6'h33, 0);
    send_word(6'h00, 0);
    check("good_done", int'(done), 1);
    check("good_cpu", int'(cpu_nReset), 1);
    cyc(2);
    check("good_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("good_w0", int'(wlog[0]), int'({5'd0, 6'h11}));
      check("good_w1", int'(wlog[1]), int'({5'd1, 6'h22}));
      check("good_w2", int'(wlog[2]), int'({5'd2, 6'h33}));
    end
    check("good_done_cnt", done_cnt, 1);

    // Bad checksum, then recovery.
    pulse_load();
    send_word(6'h02, 0);
    send_word(6'h11, 0);
    send_word(6'h22, 0);
    send_word(6'h33, 0);
    send_word(6'h01, 0);
    check("bad_err", int'(err), 1);
    check("bad_cpu", int'(cpu_nReset), 0);
    cyc(3);
    check("bad_cpu_held", int'(cpu_nReset), 0);
    pulse_load();
    check("reload_err_clr", int'(err), 0);
    done_cnt = 0;
    send_word(6'h00, 0);
    send_word(6'h15, 0);
    send_word(6'h15, 0);
    check("reload_done", int'(done), 1);
    check("reload_cpu", int'(cpu_nReset), 1);

    // Reserved header bit set.
    cyc(2);
    wlog.delete();
    pulse_load();
    send_word(6'h20, 0);
    check("hdr_err", int'(err), 1);
    cyc(2);
    check("hdr_nwrites", wlog.size(), 0);

    // Full 32-word image with rx_valid toggling.
    wlog.delete();
    done_cnt = 0;
    pulse_load();
    send_word(6'h1f, 1);
    x = '0;
    for (int i = 0; i < 32; i++) begin
      w = INS_W'($urandom);
      x = x ^ w;
      send_word(w, 1);
    end
    send_word(x, 1);
    check("full_done", int'(done), 1);
    cyc(2);
    check("full_nwrites", wlog.size(), 32);
    for (int i = 0; i < 32; i++) begin
      if (i < wlog.size()) begin
        ent = wlog[i];
        check("full_addr", int'(ent[ADDR_W+INS_W-1:INS_W]), i);
      end
    end

    // Asynchronous reset after three data words.
    pulse_load();
    send_word(6'h05, 0);
    send_word(6'h01, 0);
    send_word(6'h02, 0);
    send_word(6'h03, 0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_we", int'(pm_we), 0);
    check("areset_cpu", int'(cpu_nReset), 0);
    check("areset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_release_cpu", int'(cpu_nReset), 1);

    // Randomized images: good, bad checksum, bad header; random gaps.
    for (int t = 0; t < 25; t++) begin
      len  = int'($urandom_range(0, 31));
      mode = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 9));
      pulse_load();
      if (kind == 0) begin
        send_word(6'h20 | INS_W'($urandom_range(0, 31)), gap_for(mode));
      end else begin
        send_word(INS_W'(len), gap_for(mode));
        x = '0;
        for (int i = 0; i <= len; i++) begin
          w = INS_W'($urandom);
          x = x ^ w;
          send_word(w, gap_for(mode));
        end
        if (kind == 1) x = x ^ INS_W'(1 << $urandom_range(0, 5));
        send_word(x, gap_for(mode));
      end
      repeat (int'($urandom_range(1, 4))) begin
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = INS_W'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b0;
    end

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
